mem_port_arbiter: RTL and testbench

- Shares the single backing-memory port between three cache requesters: I-cache refill (req 0), D-cache refill (req 1) and D-cache writeback (req 2).
- Grants one requester at a time for a full fixed-length burst, using round-robin arbitration.
- Drives the 2-bit select of the existing 3-input 32-bit address/write-data mux in front of the memory port.
- Sits between the cache controllers and the memory interface in the pipelined-plus-cache core.

---
 rtl/mem_arb_pkg.sv | 54 +++++
 rtl/mem_port_arbiter_rr_picker.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types, select encodings and one-hot helpers for the
//            backing-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Number of cache requesters sharing the memory port
  localparam int NUM_REQ = 3;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Encodings understood by the existing 3-input address/write-data mux.
  // 2'b10 is not a legal mux input and is never produced.
  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b11;

  // Initial last-grant pointer: pointing at requester 2 makes requester 0
  // the first one searched after reset.
  localparam logic [1:0] LAST_RESET = 2'd2;

  // Mux select for a one-hot grant; zero grant maps to the requester-0 input
  function automatic logic [1:0] sel_of(input logic [NUM_REQ-1:0] onehot);
    logic [1:0] sel;
    sel = SEL_REQ0;
    case (onehot)
      3'b010:  sel = SEL_REQ1;
      3'b100:  sel = SEL_REQ2;
      default: sel = SEL_REQ0;
    endcase
    return sel;
  endfunction

  // Requester index for a one-hot grant
  function automatic logic [1:0] idx_of(input logic [NUM_REQ-1:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    case (onehot)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin pick among three requesters. The
//            search starts just after the last granted requester and wraps,
//            so the last winner is considered last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  // Search order (last+1, last+2, last) mod 3; an out-of-range pointer is
  // treated like requester 2 so the pick is always well defined.
  always_comb begin
    winner_o = '0;
    case (last_i)
      2'd0: begin
        if      (req_i[1]) winner_o = 3'b010;
        else if (req_i[2]) winner_o = 3'b100;
        else if (req_i[0]) winner_o = 3'b001;
      end
      2'd1: begin
        if      (req_i[2]) winner_o = 3'b100;
        else if (req_i[0]) winner_o = 3'b001;
        else if (req_i[1]) winner_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) winner_o = 3'b001;
        else if (req_i[1]) winner_o = 3'b010;
        else if (req_i[2]) winner_o = 3'b100;
      end
    endcase
  end

  assign valid_o = |req_i;

endmodule : rr_picker
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin owner of the single backing-memory port shared by
//            I-cache refill (0), D-cache refill (1) and D-cache writeback (2).
//            A winner holds the port for a full BURST_LEN-beat burst; the
//            grant, mux select and beat index are all registered.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int BURST_LEN = 4,
  localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [1:0]          sel_o,
  output logic                mem_req_o,
  input  logic                mem_ack_i,
  output logic [BEAT_W-1:0]   beat_o,
  output logic [NUM_REQ-1:0]  done_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_t          state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [1:0]          sel_q;
  logic                mem_req_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [1:0]          last_q;

  logic [NUM_REQ-1:0]  winner;
  logic                win_valid;
  logic [BEAT_W-1:0]   beat_d;
  logic [1:0]          last_d;
  logic                last_beat;

  rr_picker u_picker (
    .req_i    (req_i),
    .last_i   (last_q),
    .winner_o (winner),
    .valid_o  (win_valid)
  );

  // Next beat index, burst-end detect and the pointer value taken at burst end
  always_comb begin
    beat_d    = beat_q + 1'b1;
    last_beat = (beat_q == LAST_BEAT);
    last_d    = idx_of(gnt_q);
  end

  // Arbiter FSM: grant in IDLE, count acked beats in BUSY, release on last ack.
  // req_i is only looked at in IDLE, which gives the grant lock for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= SEL_REQ0;
      mem_req_q <= 1'b0;
      beat_q    <= '0;
      done_q    <= '0;
      last_q    <= LAST_RESET;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q   <= BUSY;
            gnt_q     <= winner;
            sel_q     <= sel_of(winner);
            mem_req_q <= 1'b1;
            beat_q    <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (last_beat) begin
              // Completion: pulse done, drop the port and force one IDLE cycle
              state_q   <= IDLE;
              done_q    <= gnt_q;
              gnt_q     <= '0;
              sel_q     <= SEL_REQ0;
              mem_req_q <= 1'b0;
              beat_q    <= '0;
              last_q    <= last_d;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign mem_req_o = mem_req_q;
  assign beat_o    = beat_q;
  assign done_o    = done_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Two instances: the
//            default 4-beat build and a 1-beat build, each compared cycle by
//            cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req0, req1;
  logic       ack0, ack1;
  logic [2:0] gnt0, gnt1, done0, done1;
  logic [1:0] sel0, sel1;
  logic       mreq0, mreq1;
  logic [1:0] beat0;
  logic [0:0] beat1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.BURST_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .gnt_o(gnt0), .sel_o(sel0),
    .mem_req_o(mreq0), .mem_ack_i(ack0), .beat_o(beat0), .done_o(done0)
  );

  mem_port_arbiter #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req1), .gnt_o(gnt1), .sel_o(sel1),
    .mem_req_o(mreq1), .mem_ack_i(ack1), .beat_o(beat1), .done_o(done1)
  );

  // Observed outputs packed as {gnt, sel, mem_req, beat(2b), done}
  logic [10:0] act0, act1;
  assign act0 = {gnt0, sel0, mreq0, beat0, done0};
  assign act1 = {gnt1, sel1, mreq1, 1'b0, beat1, done1};

  // ---------------- reference model (per instance) ----------------
  int         bl[2] = '{4, 1};
  bit         m_busy[2];
  int         m_owner[2];
  int         m_beats[2];
  int         m_last[2];
  logic [2:0] m_done[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_owner[d] = 0;
      m_beats[d] = 0;
      m_last[d]  = 2;
      m_done[d]  = 3'b000;
    end
  endtask

  // One clock of the arbitration rules for instance d with inputs r, a
  task automatic model_step(input int d, input logic [2:0] r, input logic a);
    int idx;
    m_done[d] = 3'b000;
    if (!m_busy[d]) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last[d] + k) % 3;
        if (!m_busy[d] && r[idx]) begin
          m_busy[d]  = 1'b1;
          m_owner[d] = idx;
          m_beats[d] = 0;
        end
      end
    end else if (a) begin
      if (m_beats[d] == bl[d] - 1) begin
        m_done[d]  = 3'b001 << m_owner[d];
        m_busy[d]  = 1'b0;
        m_last[d]  = m_owner[d];
        m_beats[d] = 0;
      end else begin
        m_beats[d] = m_beats[d] + 1;
      end
    end
  endtask

  function automatic logic [10:0] expv(input int d);
    logic [2:0] g;
    logic [1:0] s;
    logic [1:0] b;
    g = m_busy[d] ? (3'b001 << m_owner[d]) : 3'b000;
    s = !m_busy[d] ? 2'b00 : (m_owner[d] == 2) ? 2'b11 : 2'(m_owner[d]);
    b = m_busy[d] ? 2'(m_beats[d]) : 2'b00;
    return {g, s, m_busy[d], b, m_done[d]};
  endfunction

  // Advance one clock: the model consumes the same inputs the DUTs see
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0, req0, ack0);
      model_step(1, req1, ack1);
    end
    #1;
  endtask

  task automatic apply_reset();
    req0 = 3'b000; req1 = 3'b000; ack0 = 1'b0; ack1 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req0 = 3'b111; req1 = 3'b111; ack0 = 1'b1; ack1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (act0 !== 11'd0) begin
        fails++; $display("FAIL reset_dut4 cyc=%0d act=%h exp=%h", i, act0, 11'd0);
      end
      tests++;
      if (act1 !== 11'd0) begin
        fails++; $display("FAIL reset_dut1 cyc=%0d act=%h exp=%h", i, act1, 11'd0);
      end
    end
    req0 = 3'b000; req1 = 3'b000; ack0 = 1'b0; ack1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int done_cyc;
    done_cyc = -1;
    apply_reset();
    req0 = 3'b001;
    tick();
    tests++;
    if (act0 !== expv(0) || gnt0 !== 3'b001 || mreq0 !== 1'b1) begin
      fails++; $display("FAIL single_grant act=%h exp=%h", act0, expv(0));
    end
    ack0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (act0 !== expv(0)) begin
        fails++; $display("FAIL single cyc=%0d act=%h exp=%h", i, act0, expv(0));
      end
      if (done0 !== 3'b000) begin
        if (done_cyc < 0) done_cyc = i;
        req0 = 3'b000;
      end
    end
    tests++;
    if (done_cyc != 3) begin
      fails++; $display("FAIL single_done_cycle act=%0d exp=%0d", done_cyc, 3);
    end
    ack0 = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] order[4];
    logic [2:0] seen[$];
    logic [2:0] prev;
    int         zrun;
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    req0 = 3'b111; ack0 = 1'b1;
    prev = 3'b000; zrun = 0;
    for (int i = 0; i < 26; i++) begin
      tick();
      tests++;
      if (act0 !== expv(0)) begin
        fails++; $display("FAIL rr cyc=%0d act=%h exp=%h", i, act0, expv(0));
      end
      if (gnt0 !== 3'b000 && prev === 3'b000) begin
        if (seen.size() > 0) begin
          tests++;
          if (zrun != 1) begin
            fails++; $display("FAIL rr_idle_gap act=%0d exp=%0d", zrun, 1);
          end
        end
        seen.push_back(gnt0);
      end
      zrun = (gnt0 === 3'b000) ? zrun + 1 : 0;
      prev = gnt0;
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= seen.size() || seen[k] !== order[k]) begin
        fails++;
        $display("FAIL rr_order idx=%0d act=%b exp=%b", k,
                 (k < seen.size()) ? seen[k] : 3'bxxx, order[k]);
      end
    end
    req0 = 3'b000; ack0 = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_ack_stalls();
    logic [6:0] pat;
    pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    apply_reset();
    req0 = 3'b100;
    tick();
    req0 = 3'b000;
    tests++;
    if (act0 !== expv(0) || sel0 !== 2'b11) begin
      fails++; $display("FAIL stall_grant act=%h exp=%h", act0, expv(0));
    end
    for (int i = 0; i < 7; i++) begin
      ack0 = pat[i];
      tick();
      tests++;
      if (act0 !== expv(0)) begin
        fails++; $display("FAIL stall cyc=%0d act=%h exp=%h", i, act0, expv(0));
      end
      tests++;
      if (i < 6 && (sel0 !== 2'b11 || done0 !== 3'b000)) begin
        fails++; $display("FAIL stall_hold cyc=%0d act=sel%b/done%b exp=sel11/done000", i, sel0, done0);
      end else if (i == 6 && (done0 !== 3'b100 || gnt0 !== 3'b000)) begin
        fails++; $display("FAIL stall_done act=done%b/gnt%b exp=done100/gnt000", done0, gnt0);
      end
    end
    ack0 = 1'b0;
    tick();
    tests++;
    if (act0 !== expv(0)) begin
      fails++; $display("FAIL stall_after act=%h exp=%h", act0, expv(0));
    end
  endtask

  task automatic test_req_drop();
    bit saw;
    saw = 1'b0;
    apply_reset();
    req0 = 3'b010;
    tick();
    ack0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (act0 !== expv(0)) begin
        fails++; $display("FAIL drop cyc=%0d act=%h exp=%h", i, act0, expv(0));
      end
      if (beat0 === 2'd1) req0 = 3'b000;
      if (done0 === 3'b010) saw = 1'b1;
    end
    tests++;
    if (!saw) begin
      fails++; $display("FAIL drop_done act=%0d exp=%0d", saw, 1);
    end
    ack0 = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    req0 = 3'b001;
    tick();
    req0 = 3'b000;
    ack0 = 1'b1;
    n = 0;
    while (beat0 !== 2'd2 && n < 10) begin
      tick();
      n++;
    end
    tests++;
    if (beat0 !== 2'd2) begin
      fails++; $display("FAIL areset_reach_beat2 act=%0d exp=%0d", beat0, 2);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (act0 !== 11'd0) begin
      fails++; $display("FAIL areset_immediate act=%h exp=%h", act0, 11'd0);
    end
    @(posedge clk); #1;
    tests++;
    if (act0 !== 11'd0) begin
      fails++; $display("FAIL areset_hold act=%h exp=%h", act0, 11'd0);
    end
    rst_n = 1'b1;
    ack0 = 1'b0;
    req0 = 3'b101;
    tick();
    tests++;
    if (act0 !== expv(0) || gnt0 !== 3'b001) begin
      fails++; $display("FAIL areset_first_grant act=%h exp=%h", act0, expv(0));
    end
    req0 = 3'b000;
    ack0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (act0 !== expv(0)) begin
        fails++; $display("FAIL areset_after cyc=%0d act=%h exp=%h", i, act0, expv(0));
      end
    end
    ack0 = 1'b0;
  endtask

  task automatic test_burst1();
    logic [2:0] gq[$];
    logic [2:0] dq[$];
    logic [2:0] prev;
    apply_reset();
    req1 = 3'b110; ack1 = 1'b1;
    prev = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests++;
      if (act1 !== expv(1)) begin
        fails++; $display("FAIL b1 cyc=%0d act=%h exp=%h", i, act1, expv(1));
      end
      tests++;
      if (sel1 === 2'b10) begin
        fails++; $display("FAIL b1_sel cyc=%0d act=%b exp=not10", i, sel1);
      end
      if (gnt1 !== 3'b000 && prev === 3'b000) gq.push_back(gnt1);
      if (done1 !== 3'b000) dq.push_back(done1);
      prev = gnt1;
    end
    tests++;
    if (gq.size() < 2 || gq[0] !== 3'b010 || gq[1] !== 3'b100) begin
      fails++; $display("FAIL b1_grants act_n=%0d exp=010,100", gq.size());
    end
    tests++;
    if (dq.size() < 2 || dq[0] !== 3'b010 || dq[1] !== 3'b100) begin
      fails++; $display("FAIL b1_dones act_n=%0d exp=010,100", dq.size());
    end
    req1 = 3'b000; ack1 = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req1 = 3'($urandom_range(0, 7));
      ack0 = 1'($urandom_range(0, 1));
      ack1 = 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (act0 !== expv(0)) begin
        fails++; $display("FAIL rand4 cyc=%0d act=%h exp=%h", i, act0, expv(0));
      end
      tests++;
      if (act1 !== expv(1)) begin
        fails++; $display("FAIL rand1 cyc=%0d act=%h exp=%h", i, act1, expv(1));
      end
    end
    req0 = 3'b000; req1 = 3'b000; ack0 = 1'b0; ack1 = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_ack_stalls();
    test_req_drop();
    test_async_reset();
    test_burst1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
